video_upscaler_2x2: RTL and testbench

VIDEO_UPSCALER_2X2 -- requirements
Module: video_upscaler_2x2

---
 rtl/video_upscaler_2x2.sv | 217 +++++++++++++++++++++
 tb/tb_video_upscaler_2x2.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_upscaler_2x2.sv
// video_upscaler_2x2
//   2x2 pixel-replicating upscaler on a valid/ready video stream. Each input
//   pixel goes out twice on the live pass (PASS1) and is stored in a line
//   buffer. After the line's last pixel, the stored line is replayed with
//   every pixel doubled again (PASS2).
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   up_data/valid    : input pixel beat
//   up_tlast/tuser   : end-of-line / start-of-frame markers of the input beat
//   up_ready         : input beat accepted this cycle (combinational)
//   down_data/valid  : output pixel beat (registered)
//   down_tlast/tuser : end-of-line / start-of-frame markers of the output beat
//   down_ready       : downstream accepts the output beat
//   line_ovf         : sticky, an input line was longer than the line buffer
module video_upscaler_2x2 #(
   parameter int unsigned D_WIDTH      = 8,
   parameter int unsigned LINE_A_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               up_valid,
   input  logic               up_tlast,
   input  logic               up_tuser,
   output logic               up_ready,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_valid,
   output logic               down_tlast,
   output logic               down_tuser,
   input  logic               down_ready,
   output logic               line_ovf
);

   localparam int unsigned DEPTH = 1 << LINE_A_WIDTH;
   // Pointers carry one extra bit so they can hold the value DEPTH.
   localparam int unsigned PW    = LINE_A_WIDTH + 1;

   typedef enum logic [0:0] {
      PASS1 = 1'b0,
      PASS2 = 1'b1
   } state_e;

   state_e             state_q, state_d;

   logic [D_WIDTH-1:0] data_q,    data_d;
   logic               valid_q,   valid_d;
   logic               copy_q,    copy_d;     // 0: first copy, 1: second copy
   logic               tlast_q,   tlast_d;    // registered down_tlast
   logic               tuser_q,   tuser_d;    // registered down_tuser
   logic               last_px_q, last_px_d;  // held pixel ends the line
   logic [PW-1:0]      wr_ptr_q,  wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q,  rd_ptr_d;
   logic [PW-1:0]      len_q,     len_d;
   logic               ovf_q,     ovf_d;

   logic [D_WIDTH-1:0] line_mem [DEPTH];

   logic               xfer_c;
   logic               end_c;
   logic               up_acc_c;
   logic               wr_full_c;
   logic               mem_we_c;

   // Handshake terms shared by the FSM and the datapath.
   assign xfer_c    = valid_q & down_ready;
   assign end_c     = xfer_c & copy_q & last_px_q;
   assign wr_full_c = (wr_ptr_q == PW'(DEPTH));

   // A new pixel may enter only during the live pass, when the hold register
   // is free or its second copy is leaving now. The line's last pixel blocks
   // the next input because the replay pass follows it.
   assign up_ready = ~rst & (state_q == PASS1) &
                     (~valid_q | (copy_q & down_ready & ~last_px_q));
   assign up_acc_c = up_valid & up_ready;

   assign down_data  = data_q;
   assign down_valid = valid_q;
   assign down_tlast = tlast_q;
   assign down_tuser = tuser_q;
   assign line_ovf   = ovf_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PASS1;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: each pass ends with the second copy of its last pixel.
   always_comb begin
      state_d = state_q;
      case (state_q)
         PASS1:   if (end_c) state_d = PASS2;
         PASS2:   if (end_c) state_d = PASS1;
         default: state_d = PASS1;
      endcase
   end

   // Datapath next values per state.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      copy_d    = copy_q;
      tlast_d   = tlast_q;
      tuser_d   = tuser_q;
      last_px_d = last_px_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      mem_we_c  = 1'b0;

      case (state_q)
         PASS1: begin
            if (up_acc_c) begin
               data_d    = up_data;
               valid_d   = 1'b1;
               copy_d    = 1'b0;
               tuser_d   = up_tuser;
               tlast_d   = 1'b0;
               last_px_d = up_tlast;
               if (wr_full_c) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we_c = 1'b1;
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
               if (up_tlast) begin
                  len_d = wr_full_c ? PW'(DEPTH) : (wr_ptr_q + PW'(1));
               end
            end else if (xfer_c && !copy_q) begin
               copy_d  = 1'b1;
               tuser_d = 1'b0;
               tlast_d = last_px_q;
            end else if (xfer_c && copy_q) begin
               if (last_px_q) begin
                  // Start the replay straight from entry 0, no bubble.
                  data_d    = line_mem[0];
                  valid_d   = 1'b1;
                  copy_d    = 1'b0;
                  tuser_d   = 1'b0;
                  tlast_d   = 1'b0;
                  last_px_d = (len_q == PW'(1));
                  rd_ptr_d  = PW'(1);
                  wr_ptr_d  = '0;
               end else begin
                  valid_d = 1'b0;
                  copy_d  = 1'b0;
                  tuser_d = 1'b0;
                  tlast_d = 1'b0;
               end
            end
         end

         PASS2: begin
            if (xfer_c && !copy_q) begin
               copy_d  = 1'b1;
               tlast_d = last_px_q;
            end else if (xfer_c && copy_q) begin
               if (last_px_q) begin
                  valid_d   = 1'b0;
                  copy_d    = 1'b0;
                  tlast_d   = 1'b0;
                  last_px_d = 1'b0;
               end else begin
                  data_d    = line_mem[rd_ptr_q[LINE_A_WIDTH-1:0]];
                  copy_d    = 1'b0;
                  tlast_d   = 1'b0;
                  last_px_d = ((rd_ptr_q + PW'(1)) == len_q);
                  rd_ptr_d  = rd_ptr_q + PW'(1);
               end
            end
         end

         default: begin
            valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         copy_q    <= 1'b0;
         tlast_q   <= 1'b0;
         tuser_q   <= 1'b0;
         last_px_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         len_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         copy_q    <= copy_d;
         tlast_q   <= tlast_d;
         tuser_q   <= tuser_d;
         last_px_q <= last_px_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         len_q     <= len_d;
         ovf_q     <= ovf_d;
      end
   end

   // Line buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         line_mem[wr_ptr_q[LINE_A_WIDTH-1:0]] <= up_data;
      end
   end

endmodule

// File: tb/tb_video_upscaler_2x2.sv
// Testbench for video_upscaler_2x2 (depth-4 line buffer): directed lines,
// scoreboard of expected output beats, stall stability and reset checks.
module tb_video_upscaler_2x2;

   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst;
   logic [DW-1:0] up_data;
   logic          up_valid;
   logic          up_tlast;
   logic          up_tuser;
   logic          up_ready;
   logic [DW-1:0] down_data;
   logic          down_valid;
   logic          down_tlast;
   logic          down_tuser;
   logic          down_ready;
   logic          line_ovf;

   video_upscaler_2x2 #(
      .D_WIDTH      (DW),
      .LINE_A_WIDTH (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .up_tlast   (up_tlast),
      .up_tuser   (up_tuser),
      .up_ready   (up_ready),
      .down_data  (down_data),
      .down_valid (down_valid),
      .down_tlast (down_tlast),
      .down_tuser (down_tuser),
      .down_ready (down_ready),
      .line_ovf   (line_ovf)
   );

   int vectors = 0;
   int fails   = 0;
   int beats   = 0;
   int rmode   = 0;             // 0: ready high, 1: toggle, 2: ready low

   logic [DW+1:0] exp_q[$];     // {data, tlast, tuser}
   logic [DW-1:0] mbuf [4];
   int            midx = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream ready pattern, updated just after each rising edge.
   initial begin
      down_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       down_ready = 1'b1;
            1:       down_ready = ~down_ready;
            default: down_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: pop and compare on every transfer, check hold stability.
   initial begin
      logic          have_prev;
      logic [DW+1:0] prev;
      logic [DW+1:0] e;
      logic [DW+1:0] obs;
      have_prev = 1'b0;
      prev      = '0;
      forever begin
         @(negedge clk);
         obs = {down_data, down_tlast, down_tuser};
         if (rst) begin
            have_prev = 1'b0;
         end else begin
            if (have_prev) begin
               vectors++;
               assert (down_valid === 1'b1 && obs === prev) else begin
                  fails++;
                  $error("FAIL stall_hold: observed valid=%b beat=%h required valid=1 beat=%h",
                         down_valid, obs, prev);
               end
            end
            if (down_valid === 1'b1 && down_ready === 1'b1) begin
               beats++;
               vectors++;
               if (exp_q.size() == 0) begin
                  assert (exp_q.size() != 0) else begin
                     fails++;
                     $error("FAIL extra_beat: observed beat=%h required none", obs);
                  end
               end else begin
                  e = exp_q.pop_front();
                  assert (obs === e) else begin
                     fails++;
                     $error("FAIL beat: observed %h required %h (data,tlast,tuser)", obs, e);
                  end
               end
               have_prev = 1'b0;
            end else if (down_valid === 1'b1) begin
               have_prev = 1'b1;
               prev      = obs;
            end else begin
               have_prev = 1'b0;
            end
         end
      end
   end

   // Present one pixel until accepted, then add its expected beats.
   task automatic send_px(input logic [DW-1:0] d, input logic tl, input logic tu);
      bit got;
      int n;
      got = 1'b0;
      n   = 0;
      up_data  = d;
      up_tlast = tl;
      up_tuser = tu;
      up_valid = 1'b1;
      while (!got && n < 300) begin
         @(negedge clk);
         if (up_ready === 1'b1) got = 1'b1;
         @(posedge clk);
         n++;
      end
      #1;
      up_valid = 1'b0;
      vectors++;
      assert (got) else begin
         fails++;
         $error("FAIL accept_timeout: observed no up_ready required accept of %h", d);
      end
      if (got) begin
         if (midx == 0) begin
            // A new line may only start once the previous replay is done.
            vectors++;
            assert (exp_q.size() == 0) else begin
               fails++;
               $error("FAIL early_accept: observed %0d beats pending required 0", exp_q.size());
            end
         end
         exp_q.push_back({d, 1'b0, tu});
         exp_q.push_back({d, tl, 1'b0});
         if (midx < 4) mbuf[midx] = d;
         midx++;
         if (tl) begin
            int len;
            len = (midx < 4) ? midx : 4;
            for (int i = 0; i < len; i++) begin
               exp_q.push_back({mbuf[i], 1'b0, 1'b0});
               exp_q.push_back({mbuf[i], (i == len - 1) ? 1'b1 : 1'b0, 1'b0});
            end
            midx = 0;
         end
      end
   endtask

   // Wait for the scoreboard to empty and the output to go idle.
   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || down_valid !== 1'b0) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      vectors++;
      assert (exp_q.size() == 0 && down_valid === 1'b0) else begin
         fails++;
         $error("FAIL %s drain: observed pending=%0d valid=%b required pending=0 valid=0",
                tag, exp_q.size(), down_valid);
      end
   endtask

   task automatic check_beats(input string tag, input int want);
      vectors++;
      assert (beats == want) else begin
         fails++;
         $error("FAIL %s beat_count: observed %0d required %0d", tag, beats, want);
      end
   endtask

   initial begin
      int n;
      rst      = 1'b1;
      up_data  = '0;
      up_valid = 1'b0;
      up_tlast = 1'b0;
      up_tuser = 1'b0;
      rmode    = 0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state.
      vectors++;
      assert ({down_valid, down_tlast, down_tuser, line_ovf, up_ready} === 5'b0 &&
              down_data === 8'h00) else begin
         fails++;
         $error("FAIL reset_state: observed v/tl/tu/ovf/rdy=%b data=%h required 0",
                {down_valid, down_tlast, down_tuser, line_ovf, up_ready}, down_data);
      end
      rst = 1'b0;
      @(posedge clk);
      #2;
      vectors++;
      assert (up_ready === 1'b1) else begin
         fails++;
         $error("FAIL ready_after_reset: observed %b required 1", up_ready);
      end

      // Two-pixel line, downstream always ready.
      beats = 0;
      send_px(8'hA1, 1'b0, 1'b1);
      send_px(8'hB2, 1'b1, 1'b0);
      drain("line_ready");
      check_beats("line_ready", 8);

      // Same line with downstream stalling every other cycle.
      rmode = 1;
      beats = 0;
      send_px(8'hA1, 1'b0, 1'b1);
      send_px(8'hB2, 1'b1, 1'b0);
      drain("line_toggle");
      check_beats("line_toggle", 8);
      rmode = 0;

      // Next pixel offered immediately, held off through the replay.
      beats = 0;
      send_px(8'h3A, 1'b0, 1'b1);
      send_px(8'h3B, 1'b1, 1'b0);
      send_px(8'hC3, 1'b1, 1'b0);
      drain("held_c");
      check_beats("held_c", 12);

      // Single-pixel line with both markers.
      beats = 0;
      send_px(8'h5E, 1'b1, 1'b1);
      drain("single");
      check_beats("single", 4);

      vectors++;
      assert (line_ovf === 1'b0) else begin
         fails++;
         $error("FAIL ovf_clear: observed %b required 0", line_ovf);
      end

      // Six pixels into a four-entry buffer.
      beats = 0;
      for (int i = 0; i < 6; i++) begin
         send_px(8'h10 + 8'(i), (i == 5) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0);
      end
      drain("overflow");
      check_beats("overflow", 20);
      vectors++;
      assert (line_ovf === 1'b1) else begin
         fails++;
         $error("FAIL ovf_set: observed %b required 1", line_ovf);
      end

      // Reset in the middle of the replay pass.
      send_px(8'h71, 1'b0, 1'b1);
      send_px(8'h72, 1'b1, 1'b0);
      n = 0;
      while (exp_q.size() > 2 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      rmode = 2;
      repeat (2) @(posedge clk);
      #2;
      vectors++;
      assert (down_valid === 1'b1 && line_ovf === 1'b1) else begin
         fails++;
         $error("FAIL pre_reset: observed valid=%b ovf=%b required valid=1 ovf=1",
                down_valid, line_ovf);
      end
      rst = 1'b1;
      @(posedge clk);
      #2;
      vectors++;
      assert (down_valid === 1'b0 && line_ovf === 1'b0 && up_ready === 1'b0) else begin
         fails++;
         $error("FAIL mid_reset: observed valid=%b ovf=%b rdy=%b required 0 0 0",
                down_valid, line_ovf, up_ready);
      end
      rst = 1'b0;
      exp_q.delete();
      midx  = 0;
      rmode = 0;

      // Fresh line after reset.
      beats = 0;
      send_px(8'hD4, 1'b1, 1'b0);
      drain("post_reset");
      check_beats("post_reset", 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
